// File: rtl/imu_relay_axil_fifo.sv
// -----------------------------------------------------------------------------
// imu_relay_axil_fifo
// AXI4-Lite slave for the IMU relay PL block. Exposes NUM_CFG_REGS read/write
// config registers (byte strobes honoured) and a sample FIFO that the PL IMU
// sampler fills and the PS drains over AXI-Lite.
//
// Word map (index = addr[ADDR_W-1:2]):
//   0..N-1 CFGk   RW
//   N      STATUS RO  [0] empty, [1] full, [2] overflow (sticky), [16:8] count
//   N+1    DATA   RO  read pops the FIFO head (SLVERR + 0 when empty)
//   N+2    CTRL   WO  [0] flush, [1] clear overflow; reads return 0
//   other         SLVERR
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN  clock, async active-low reset
//   S_AXI_AW* / W* / B*         AXI-Lite write address, data, response
//   S_AXI_AR* / R*              AXI-Lite read address, data
//   sample_valid / sample_data  one-cycle push strobe and sample word
//   cfg_out                     flat config registers, reg k at [32k+31:32k]
//   irq                         high while the FIFO is non-empty (registered)
// -----------------------------------------------------------------------------
module imu_relay_axil_fifo #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_CFG_REGS       = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  input  logic                                     sample_valid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            sample_data,
  output logic [C_S_AXI_DATA_WIDTH*NUM_CFG_REGS-1:0] cfg_out,
  output logic                                     irq
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(NUM_CFG_REGS);
  localparam logic [IDX_W-1:0] IDX_DATA   = IDX_W'(NUM_CFG_REGS + 1);
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(NUM_CFG_REGS + 2);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic          r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]    r_bresp, r_rresp;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_cfg [NUM_CFG_REGS];
  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic          r_ovf, r_irq;

  logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
  logic          w_wr_en, w_rd_en, w_wr_err, w_rd_err;
  logic          w_empty, w_full, w_push, w_pop, w_flush, w_ovf_set, w_ovf_clr;
  logic [CNT_W-1:0] w_count_nxt;
  logic [DW-1:0] w_status, w_rd_data;

  // Byte-offset address bits are deliberately ignored.
  logic w_unused;
  assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_wr_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Handshake cycles: the ready pulse is registered, so the transfer happens
  // on the cycle the pulse is high while the master still holds valid.
  assign w_wr_en  = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_en  = r_arready & S_AXI_ARVALID;
  assign w_wr_err = !((w_wr_idx < IDX_STATUS) || (w_wr_idx == IDX_CTRL));

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = w_rd_en & (w_rd_idx == IDX_DATA) & !w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push    = sample_valid & (!w_full | w_pop);
  assign w_ovf_set = sample_valid & w_full & !w_pop;
  assign w_flush   = w_wr_en & (w_wr_idx == IDX_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
  assign w_ovf_clr = w_wr_en & (w_wr_idx == IDX_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_status          = '0;
    w_status[0]       = w_empty;
    w_status[1]       = w_full;
    w_status[2]       = r_ovf;
    w_status[8 +: CNT_W] = r_count;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush)               w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    if (w_rd_idx < IDX_STATUS) begin
      for (int k = 0; k < NUM_CFG_REGS; k++)
        if (w_rd_idx == IDX_W'(k)) w_rd_data = r_cfg[k];
    end else if (w_rd_idx == IDX_STATUS) begin
      w_rd_data = w_status;
    end else if (w_rd_idx == IDX_DATA) begin
      if (w_empty) w_rd_err  = 1'b1;
      else         w_rd_data = r_mem[r_rptr];
    end else if (w_rd_idx != IDX_CTRL) begin
      w_rd_err = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      for (int k = 0; k < NUM_CFG_REGS; k++) r_cfg[k] <= '0;
    end else begin
      r_awready <= S_AXI_AWVALID & S_AXI_WVALID & !r_bvalid & !r_awready;
      if (w_wr_en) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end

      if (w_wr_en && (w_wr_idx < IDX_STATUS)) begin
        for (int k = 0; k < NUM_CFG_REGS; k++)
          if (w_wr_idx == IDX_W'(k))
            for (int b = 0; b < DW/8; b++)
              if (S_AXI_WSTRB[b]) r_cfg[k][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end

      r_arready <= S_AXI_ARVALID & !r_rvalid & !r_arready;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_irq   <= (w_count_nxt != '0);
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
      // Set has priority over a same-cycle clear.
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // NOTE: the sample storage has no reset; its contents are only visible
  // through the pointers, which are reset, so clearing it would be wasted logic.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_push && !w_flush) r_mem[r_wptr] <= sample_data;
  end

  for (genvar g = 0; g < NUM_CFG_REGS; g++) begin : g_cfg_out
    assign cfg_out[DW*g +: DW] = r_cfg[g];
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign irq           = r_irq;

endmodule

// File: tb/tb_imu_relay_axil_fifo.sv
// -----------------------------------------------------------------------------
// tb_imu_relay_axil_fifo
// Directed bench for imu_relay_axil_fifo (N=4 cfg regs, FIFO depth 16).
// A vector table covers register access and address decode; hand-written
// sequences cover FIFO ordering, overflow, push/pop on full, flush and
// asynchronous reset with responses outstanding.
// -----------------------------------------------------------------------------
module tb_imu_relay_axil_fifo;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bready = 1'b1, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_data = '0;
  logic [32*N-1:0] cfg_out;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imu_relay_axil_fifo #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6),
    .NUM_CFG_REGS(N), .FIFO_DEPTH(16)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .cfg_out(cfg_out), .irq(irq)
  );

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return awready;
      1:       return bvalid;
      2:       return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string what);
    int n = 0;
    while (!sig_of(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sig_of(sel)) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_%s: got 0, expected 1 within 50 cycles", what);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    wait_sig(0, "awready");
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_sig(1, "bvalid");
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    wait_sig(2, "arready");
    @(negedge clk);
    arvalid = 1'b0;
    wait_sig(3, "rvalid");
    d = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  // Drives sample_valid for cnt consecutive cycles with base+i data.
  task automatic push_burst(input int cnt, input logic [31:0] base);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = base + 32'(i);
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    // Register-access vectors: {is_wr, addr, wdata, strb, exp_rdata, exp_resp}
    vecs[0]  = '{1'b1, 6'h00, 32'd1,        4'hF, 32'h0,        2'b00};
    vecs[1]  = '{1'b1, 6'h04, 32'd2,        4'hF, 32'h0,        2'b00};
    vecs[2]  = '{1'b1, 6'h08, 32'd3,        4'hF, 32'h0,        2'b00};
    vecs[3]  = '{1'b1, 6'h0C, 32'd4,        4'hF, 32'h0,        2'b00};
    vecs[4]  = '{1'b0, 6'h00, 32'h0,        4'h0, 32'd1,        2'b00};
    vecs[5]  = '{1'b0, 6'h04, 32'h0,        4'h0, 32'd2,        2'b00};
    vecs[6]  = '{1'b0, 6'h08, 32'h0,        4'h0, 32'd3,        2'b00};
    vecs[7]  = '{1'b0, 6'h0C, 32'h0,        4'h0, 32'd4,        2'b00};
    vecs[8]  = '{1'b1, 6'h04, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00};
    vecs[9]  = '{1'b1, 6'h04, 32'h00000000, 4'h5, 32'h0,        2'b00};
    vecs[10] = '{1'b0, 6'h04, 32'h0,        4'h0, 32'hFF00FF00, 2'b00};
    vecs[11] = '{1'b0, 6'h1C, 32'h0,        4'h0, 32'h0,        2'b10};
    vecs[12] = '{1'b1, 6'h1C, 32'h123,      4'hF, 32'h0,        2'b10};
    vecs[13] = '{1'b0, 6'h3C, 32'h0,        4'h0, 32'h0,        2'b10};
    vecs[14] = '{1'b1, 6'h10, 32'hFFFF,     4'hF, 32'h0,        2'b10};
    vecs[15] = '{1'b0, 6'h10, 32'h0,        4'h0, 32'h00000001, 2'b00};
    vecs[16] = '{1'b0, 6'h18, 32'h0,        4'h0, 32'h0,        2'b00};
    vecs[17] = '{1'b1, 6'h16, 32'h1,        4'hF, 32'h0,        2'b10};
    vecs[18] = '{1'b0, 6'h0F, 32'h0,        4'h0, 32'd4,        2'b00};
    vecs[19] = '{1'b0, 6'h04, 32'h0,        4'h0, 32'hFF00FF00, 2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_cfg_lo", cfg_out[63:0] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    check("rst_cfg_hi", cfg_out[127:64] == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Register map vectors
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, r);
        check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, d, r);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end
    end
    check("cfg_out0", cfg_out[31:0], 32'd1);
    check("cfg_out1", cfg_out[63:32], 32'hFF00FF00);
    check("cfg_out3", cfg_out[127:96], 32'd4);

    // Four samples in, in-order drain, empty read
    push_burst(4, 32'hA0);
    repeat (2) @(negedge clk);
    check("t3_irq_hi", 32'(irq), 32'd1);
    axi_read(6'h10, d, r);
    check("t3_status", d, 32'h00000400);
    for (int i = 0; i < 4; i++) begin
      axi_read(6'h14, d, r);
      check($sformatf("t3_data%0d", i), d, 32'hA0 + 32'(i));
      check($sformatf("t3_resp%0d", i), 32'(r), 32'd0);
    end
    check("t3_irq_lo", 32'(irq), 32'd0);
    axi_read(6'h14, d, r);
    check("t3_empty_data", d, 32'd0);
    check("t3_empty_resp", 32'(r), 32'd2);
    axi_read(6'h10, d, r);
    check("t3_status_empty", d, 32'h00000001);

    // Overflow: 17 samples into a 16-deep FIFO
    push_burst(17, 32'h100);
    axi_read(6'h10, d, r);
    check("t4_status_ovf", d, 32'h00001006);
    for (int i = 0; i < 16; i++) begin
      axi_read(6'h14, d, r);
      check($sformatf("t4_data%0d", i), d, 32'h100 + 32'(i));
    end
    axi_read(6'h10, d, r);
    check("t4_status_drained", d, 32'h00000005);
    axi_write(6'h18, 32'h2, 4'h1, r);
    check("t4_ctrl_resp", 32'(r), 32'd0);
    axi_read(6'h10, d, r);
    check("t4_status_clr", d, 32'h00000001);

    // Full FIFO: push lands on the same cycle as a DATA pop
    push_burst(16, 32'h200);
    axi_read(6'h10, d, r);
    check("t5_status_full", d, 32'h00001002);
    @(negedge clk);
    araddr = 6'h14; arvalid = 1'b1;
    wait_sig(2, "arready_t5");
    sample_valid = 1'b1; sample_data = 32'h2FF;
    @(negedge clk);
    arvalid = 1'b0; sample_valid = 1'b0;
    wait_sig(3, "rvalid_t5");
    check("t5_pop_data", rdata, 32'h200);
    @(negedge clk);
    axi_read(6'h10, d, r);
    check("t5_status_no_ovf", d, 32'h00001002);
    axi_read(6'h14, d, r);
    check("t5_next_data", d, 32'h201);
    axi_write(6'h18, 32'h1, 4'h1, r);
    axi_read(6'h10, d, r);
    check("t5_status_flush", d, 32'h00000001);
    check("t5_irq_flush", 32'(irq), 32'd0);
    push_burst(1, 32'h77);
    axi_read(6'h14, d, r);
    check("t5_after_flush", d, 32'h77);

    // Reset with B and R responses held outstanding
    push_burst(2, 32'h300);
    bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    awaddr = 6'h00; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    wait_sig(0, "awready_t6");
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_bvalid_hold", 32'(bvalid), 32'd1);
    check("t6_cfg0", cfg_out[31:0], 32'h55);
    araddr = 6'h10; arvalid = 1'b1;
    wait_sig(2, "arready_t6");
    @(negedge clk);
    arvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rvalid_hold", 32'(rvalid), 32'd1);
    check("t6_rdata", rdata, 32'h00000200);
    @(negedge clk);
    check("t6_rdata_stable", rdata, 32'h00000200);
    check("t6_irq_pre", 32'(irq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_bvalid", 32'(bvalid), 32'd0);
    check("t6_rst_rvalid", 32'(rvalid), 32'd0);
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_cfg0", cfg_out[31:0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
    axi_read(6'h10, d, r);
    check("t6_status_count0", d, 32'h00000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
